gpio_cmd_master: RTL and testbench

GPIO_CMD_MASTER -- requirements
Module: gpio_cmd_master

---
 rtl/gpio_cmd_master.sv | 234 +++++++++++++++++++++++
 tb/tb_gpio_cmd_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : gpio_cmd_master
// Purpose  : Sequences one command onto a GPIO register-file interface.
//            Sequence: SETUP, strobe high for N_HOLD cycles (skipped for a
//            NOP), RELEASE, wait N_WAIT cycles, then capture the response.
// Ports    : clk          - rising-edge clock
//            i_reset      - asynchronous active-low reset
//            i_req        - command request (taken when o_req_ready=1)
//            i_opcode     - 8-bit opcode
//            i_data       - 23-bit payload
//            i_gpio_resp  - response word from the register file
//            o_gpio_cmd   - {opcode, strobe, payload} command word
//            o_req_ready  - a request can be accepted on this edge
//            o_busy       - transaction in progress
//            o_done       - one-cycle completion pulse
//            o_resp_data  - captured response word
// Options  : GPIO_CMD_QUEUE_EN - adds a 4-entry command FIFO before the FSM
// Revision : 1.0 - initial release
// ============================================================================
module gpio_cmd_master #(
    parameter int NBT_GPIOS = 32,
    parameter int N_HOLD    = 4,
    parameter int N_WAIT    = 8
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_req,
    input  logic [7:0]           i_opcode,
    input  logic [22:0]          i_data,
    input  logic [NBT_GPIOS-1:0] i_gpio_resp,
    output logic [NBT_GPIOS-1:0] o_gpio_cmd,
    output logic                 o_req_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NBT_GPIOS-1:0] o_resp_data
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CAPTURE = 3'd5
    } state_t;

    // Counters load length-1 on entry and leave the state when they hit zero.
    localparam logic [7:0] C_HOLD_LOAD = 8'(N_HOLD - 1);
    localparam logic [7:0] C_WAIT_LOAD = 8'(N_WAIT - 1);
    localparam logic [7:0] C_OP_NOP    = 8'h00;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [7:0]             op_q, op_d;
    logic [22:0]            data_q, data_d;
    logic [NBT_GPIOS-1:0]   cmd_q, cmd_d;
    logic [NBT_GPIOS-1:0]   resp_q, resp_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;

    logic                   w_accept;
    logic                   w_start;
    logic [7:0]             w_start_op;
    logic [22:0]            w_start_data;

    assign w_accept = i_req & ready_q;

`ifdef GPIO_CMD_QUEUE_EN
    localparam logic [2:0] C_QDEPTH = 3'd4;

    logic [30:0] fifo_q [4];
    logic [30:0] fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        w_pop;
    logic        w_fifo_wr;

    // In IDLE the FIFO head has priority; an accepted request only bypasses
    // the FIFO when it is empty, which keeps commands in arrival order.
    always_comb begin
        w_pop        = 1'b0;
        w_fifo_wr    = w_accept;
        w_start      = 1'b0;
        w_start_op   = i_opcode;
        w_start_data = i_data;
        if (state_q == ST_IDLE) begin
            if (count_q != 3'd0) begin
                w_pop                      = 1'b1;
                w_start                    = 1'b1;
                {w_start_op, w_start_data} = fifo_q[rd_ptr_q];
            end else if (w_accept) begin
                w_start   = 1'b1;
                w_fifo_wr = 1'b0;
            end
        end
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_fifo_wr) begin
            fifo_d[wr_ptr_q] = {i_opcode, i_data};
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, w_fifo_wr} - {2'b00, w_pop};
    end
`else
    always_comb begin
        w_start      = (state_q == ST_IDLE) && w_accept;
        w_start_op   = i_opcode;
        w_start_data = i_data;
    end
`endif

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_SETUP;
                    cnt_d   = 8'd0;
                    op_d    = w_start_op;
                    data_d  = w_start_data;
                end
            end
            ST_SETUP: begin
                if (op_q == C_OP_NOP) begin
                    state_d = ST_RELEASE;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_STROBE;
                    cnt_d   = C_HOLD_LOAD;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_WAIT;
                cnt_d   = C_WAIT_LOAD;
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Registered outputs: command/done/response follow the current state one
    // cycle later, while busy/ready track the next state so that ready is
    // already low on the edge after an acceptance.
    always_comb begin
        cmd_d  = NBT_GPIOS'({op_q, (state_q == ST_STROBE), data_q});
        done_d = (state_q == ST_CAPTURE);
        resp_d = (state_q == ST_CAPTURE) ? i_gpio_resp : resp_q;
        busy_d = (state_d != ST_IDLE);
`ifdef GPIO_CMD_QUEUE_EN
        ready_d = (count_d != C_QDEPTH);
`else
        ready_d = (state_d == ST_IDLE);
`endif
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            op_q     <= 8'd0;
            data_q   <= 23'd0;
            cmd_q    <= '0;
            resp_q   <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef GPIO_CMD_QUEUE_EN
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 31'd0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            data_q   <= data_d;
            cmd_q    <= cmd_d;
            resp_q   <= resp_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
`ifdef GPIO_CMD_QUEUE_EN
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`endif
        end
    end

    assign o_gpio_cmd  = cmd_q;
    assign o_resp_data = resp_q;
    assign o_busy      = busy_q;
    assign o_req_ready = ready_q;
    assign o_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_cmd_master
// Purpose  : Self-checking bench for gpio_cmd_master (default parameters).
//            Table of single transactions checked cycle by cycle, plus
//            hand-written reset-abort, busy-request and queue sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_cmd_master;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req = 1'b0;
    logic [7:0]  i_opcode = 8'd0;
    logic [22:0] i_data = 23'd0;
    logic [31:0] i_gpio_resp = 32'd0;
    logic [31:0] o_gpio_cmd;
    logic        o_req_ready;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_resp_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  op;
        logic [22:0] data;
        logic [31:0] resp;
        int          lat;    // edges from acceptance to the o_done cycle
    } vec_t;

    vec_t vecs[4];

    gpio_cmd_master #(
        .NBT_GPIOS (32),
        .N_HOLD    (4),
        .N_WAIT    (8)
    ) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_opcode    (i_opcode),
        .i_data      (i_data),
        .i_gpio_resp (i_gpio_resp),
        .o_gpio_cmd  (o_gpio_cmd),
        .o_req_ready (o_req_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_resp_data (o_resp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_req_ready && n < 60) begin
            step();
            n++;
        end
        check("ready_timeout", {31'd0, o_req_ready}, 32'd1);
    endtask

    // One transaction, every cycle checked against hand-derived timing:
    // strobe after edges k+2..k+5, done after edge k+lat. The response is
    // only valid during the CAPTURE cycle so a mistimed capture shows up.
    task automatic run_vec(input vec_t v);
        logic [31:0] exp_cmd;
        logic        exp_str;
        wait_ready();
        i_req    = 1'b1;
        i_opcode = v.op;
        i_data   = v.data;
        step();                       // acceptance edge k
        i_req    = 1'b0;
        for (int j = 1; j <= v.lat + 2; j++) begin
            i_gpio_resp = (j == v.lat) ? v.resp : ~v.resp;
            step();
            exp_str = (v.op != 8'h00) && (j >= 2) && (j <= 5);
            exp_cmd = {v.op, exp_str, v.data};
            check("gpio_cmd", o_gpio_cmd, exp_cmd);
            check("done", {31'd0, o_done}, {31'd0, (j == v.lat)});
            check("busy", {31'd0, o_busy}, {31'd0, (j < v.lat)});
`ifdef GPIO_CMD_QUEUE_EN
            check("ready", {31'd0, o_req_ready}, 32'd1);
`else
            check("ready", {31'd0, o_req_ready}, {31'd0, (j >= v.lat)});
`endif
            if (j >= v.lat)
                check("resp_data", o_resp_data, v.resp);
        end
    endtask

    // Start a transaction, then pull reset low mid-cycle after edge k+jr.
    task automatic abort_at(input int jr);
        wait_ready();
        i_req    = 1'b1;
        i_opcode = 8'h3C;
        i_data   = 23'h000001;
        step();
        i_req    = 1'b0;
        for (int j = 1; j <= jr; j++) step();
        check("abort_strobe_before", {31'd0, o_gpio_cmd[23]}, {31'd0, (jr >= 2 && jr <= 5)});
        #1 i_reset = 1'b0;
        #1;
        check("abort_cmd", o_gpio_cmd, 32'd0);
        check("abort_resp", o_resp_data, 32'd0);
        check("abort_flags", {28'd0, o_done, o_busy, o_req_ready, 1'b0}, 32'd0);
        for (int j = 0; j < 3; j++) begin
            step();
            check("abort_hold_done", {31'd0, o_done}, 32'd0);
        end
        i_reset = 1'b1;
        #1;
        check("abort_ready_low", {31'd0, o_req_ready}, 32'd0);
        step();
        check("abort_ready_rise", {31'd0, o_req_ready}, 32'd1);
        for (int j = 0; j < 20; j++) begin
            step();
            check("abort_no_done", {30'd0, o_done, o_busy}, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{op: 8'h01, data: 23'h000005, resp: 32'hDEADBEEF, lat: 15};
        vecs[1] = '{op: 8'h00, data: 23'h7FFFFF, resp: 32'h12345678, lat: 11};
        vecs[2] = '{op: 8'hFF, data: 23'h7FFFFF, resp: 32'hFFFFFFFF, lat: 15};
        vecs[3] = '{op: 8'hA5, data: 23'h2AAAAA, resp: 32'h00000000, lat: 15};

        // Reset state, with no clock edge needed.
        #2;
        check("rst_cmd", o_gpio_cmd, 32'd0);
        check("rst_resp", o_resp_data, 32'd0);
        check("rst_flags", {29'd0, o_done, o_busy, o_req_ready}, 32'd0);
        step();
        step();
        i_reset = 1'b1;
        #1;
        check("rel_ready_low", {31'd0, o_req_ready}, 32'd0);
        step();
        check("rel_ready_rise", {31'd0, o_req_ready}, 32'd1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        abort_at(6);
        run_vec(vecs[0]);
        abort_at(3);
        run_vec(vecs[1]);

`ifdef GPIO_CMD_QUEUE_EN
        begin : q_test
            int  sent = 0;
            int  nd   = 0;
            int  guard = 0;
            logic r;
            wait_ready();
            i_req    = 1'b1;
            i_opcode = 8'd1;
            i_data   = 23'h000100;
            while (sent < 5 && guard < 20) begin
                r = o_req_ready;
                step();
                guard++;
                if (r) begin
                    sent++;
                    i_opcode = 8'(sent + 1);
                    i_data   = 23'(32'h100 + sent);
                    if (sent == 5) i_req = 1'b0;
                end
            end
            i_req = 1'b0;
            check("q_sent", sent, 5);
            check("q_full_ready", {31'd0, o_req_ready}, 32'd0);
            for (int j = 0; j < 150 && nd < 5; j++) begin
                step();
                if (o_done) begin
                    check("q_order_op", {24'd0, o_gpio_cmd[31:24]}, 32'(nd + 1));
                    check("q_order_data", {9'd0, o_gpio_cmd[22:0]}, 32'h100 + 32'(nd));
                    nd++;
                end
            end
            check("q_done_count", nd, 5);
            step();
            check("q_ready_after", {31'd0, o_req_ready}, 32'd1);
        end
`else
        begin : busy_test
            int nd  = 0;
            int bad = 0;
            wait_ready();
            i_req    = 1'b1;
            i_opcode = 8'h11;
            i_data   = 23'h000022;
            step();
            i_req = 1'b0;
            for (int j = 1; j <= 40; j++) begin
                if (j == 3) begin
                    check("busy_ready_low", {31'd0, o_req_ready}, 32'd0);
                    i_req    = 1'b1;
                    i_opcode = 8'h77;
                    i_data   = 23'h000333;
                end else begin
                    i_req = 1'b0;
                end
                step();
                if (o_done) nd++;
                if (o_gpio_cmd[31:24] == 8'h77) bad++;
            end
            check("busy_done_count", nd, 1);
            check("busy_no_side_effect", bad, 0);
            check("busy_last_cmd", o_gpio_cmd, 32'h11000022);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
